// File: rtl/sd_bus_arbiter_if.sv
// Engine-side bundle for the SD SPI arbiter: per-engine request/grant, per-engine
// MOSI/CSn lanes, and the single muxed link toward the card pins.
interface sd_bus_arbiter_if;
  logic       init_ok;
  logic [2:0] req;
  logic [2:0] mosi_i;
  logic [2:0] csn_i;
  logic [2:0] gnt;
  logic       SD_MOSI;
  logic       SD_CSn;
  logic       busy;
  logic       timeout_err;

  modport master (
    output init_ok, req, mosi_i, csn_i,
    input  gnt, SD_MOSI, SD_CSn, busy, timeout_err
  );

  modport slave (
    input  init_ok, req, mosi_i, csn_i,
    output gnt, SD_MOSI, SD_CSn, busy, timeout_err
  );
endinterface

// File: rtl/sd_bus_arbiter.sv
// Arbitrates the SD card SPI link between the init, block-read and block-write
// engines, with an enforced CS-high gap between owners and a hold-time limit.
module sd_bus_arbiter #(
  parameter int HOLD_MAX   = 4095,
  parameter int GAP_CYCLES = 8
) (
  input logic            SD_CK,
  input logic            rst,
  sd_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [1:0]  OWN_INIT  = 2'd0;
  localparam logic [1:0]  OWN_READ  = 2'd1;
  localparam logic [1:0]  OWN_WRITE = 2'd2;
  localparam logic [11:0] HOLD_LAST = 12'(HOLD_MAX - 1);
  localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [1:0]  own;
  logic        last_rw;   // 1: write was served last, 0: read
  logic [11:0] hold_cnt;
  logic [3:0]  gap_cnt;
  logic [2:0]  revoked;
  logic [2:0]  gnt_q;
  logic        timeout_q;

  logic [2:0]  eligible;
  logic        pick_any;
  logic [1:0]  pick_own;
  logic        own_req;
  logic        own_csn;
  logic        own_mosi;
  logic        hit_timeout;
  logic        card_mismatch;
  logic        exit_grant;
  logic [2:0]  revoke_set;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eligible = 3'b000;
    if (bus.init_ok) eligible[2:1] = bus.req[2:1] & ~revoked[2:1];
    else             eligible[0]   = bus.req[0]   & ~revoked[0];

    pick_any = |eligible;
    pick_own = OWN_INIT;
    if (eligible[1] && eligible[2]) pick_own = last_rw ? OWN_READ : OWN_WRITE;
    else if (eligible[1])           pick_own = OWN_READ;
    else if (eligible[2])           pick_own = OWN_WRITE;
  end

  always_comb begin
    own_req  = bus.req[0];
    own_csn  = bus.csn_i[0];
    own_mosi = bus.mosi_i[0];
    case (own)
      OWN_READ: begin
        own_req  = bus.req[1];
        own_csn  = bus.csn_i[1];
        own_mosi = bus.mosi_i[1];
      end
      OWN_WRITE: begin
        own_req  = bus.req[2];
        own_csn  = bus.csn_i[2];
        own_mosi = bus.mosi_i[2];
      end
      default: ;
    endcase
  end

  // Init owns the bus only before the card is up; read/write only after.
  assign hit_timeout   = (hold_cnt == HOLD_LAST);
  assign card_mismatch = (own == OWN_INIT) ? bus.init_ok : !bus.init_ok;
  assign exit_grant    = hit_timeout || card_mismatch || !own_req;
  assign revoke_set    = (state == S_GRANT && (hit_timeout || card_mismatch))
                         ? (3'b001 << own) : 3'b000;

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge SD_CK or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      own       <= OWN_INIT;
      last_rw   <= 1'b1;
      hold_cnt  <= 12'd0;
      gap_cnt   <= 4'd0;
      revoked   <= 3'b000;
      gnt_q     <= 3'b000;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      // A revoked requester stays blocked until it lets go of req for a cycle.
      revoked   <= bus.req & (revoked | revoke_set);
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            state    <= S_GRANT;
            own      <= pick_own;
            gnt_q    <= 3'b001 << pick_own;
            hold_cnt <= 12'd0;
            if (pick_own != OWN_INIT) last_rw <= (pick_own == OWN_WRITE);
          end
        end
        S_GRANT: begin
          if (exit_grant) begin
            state     <= S_GAP;
            gnt_q     <= 3'b000;
            gap_cnt   <= 4'd0;
            timeout_q <= hit_timeout;
          end else begin
            hold_cnt <= hold_cnt + 12'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.SD_CSn      = (state == S_GRANT) ? own_csn  : 1'b1;
  assign bus.SD_MOSI     = (state == S_GRANT) ? own_mosi : 1'b1;
  assign bus.busy        = (state != S_IDLE);
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Directed bench for sd_bus_arbiter: a vector table for the init-phase handshake,
// then hand-written sequences for round-robin, hold timeout, card loss and reset.
module tb_sd_bus_arbiter;

  localparam int GAP = 8;

  logic SD_CK = 1'b0;
  logic rst   = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  sd_bus_arbiter_if bus ();

  sd_bus_arbiter #(.HOLD_MAX(4095), .GAP_CYCLES(GAP)) dut (
    .SD_CK (SD_CK),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 SD_CK = ~SD_CK;

  typedef struct {
    logic       init_ok;
    logic [2:0] req;
    logic [2:0] mosi;
    logic [2:0] csn;
    logic [2:0] exp_gnt;
    logic       exp_csn;
    logic       exp_mosi;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    bus.init_ok = 1'b0;
    bus.req    = 3'b000;
    bus.mosi_i = 3'b000;
    bus.csn_i  = 3'b111;
    repeat (2) @(negedge SD_CK);
    rst = 1'b0;
  endtask

  // Read engine requests alone; it drops req once it has seen drop_at grant cycles.
  task automatic hold_run(input int drop_at, output int gcyc, output int pulses,
                          output logic [2:0] end_gnt, output logic end_busy);
    apply_reset();
    bus.init_ok = 1'b1;
    bus.req     = 3'b010;
    gcyc   = 0;
    pulses = 0;
    for (int c = 0; c < 4130; c++) begin
      @(posedge SD_CK); #1;
      if (bus.gnt == 3'b010) gcyc++;
      if (bus.timeout_err)   pulses++;
      if (gcyc == drop_at)   bus.req = 3'b000;
    end
    end_gnt  = bus.gnt;
    end_busy = bus.busy;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] owner;
    logic [2:0] exp_next [2];
    logic [2:0] eg;
    logic       eb;
    int         zero_cyc, busy_cyc, csn_hi, gcyc, pulses, bad, terr_cnt;
    bit         seen;

    //              init req     mosi    csn     gnt     csn  mosi busy
    vecs[0]  = '{1'b0, 3'b011, 3'b000, 3'b111, 3'b001, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 3'b011, 3'b001, 3'b100, 3'b001, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 3'b011, 3'b110, 3'b110, 3'b001, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1};
    for (int i = 4; i <= 10; i++)
      vecs[i] = '{1'b0, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 3'b010, 3'b101, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 3'b110, 3'b010, 3'b101, 3'b010, 1'b0, 1'b1, 1'b1};

    apply_reset();
    check("reset gnt",  bus.gnt, 3'b000);
    check("reset csn",  bus.SD_CSn, 1'b1);
    check("reset mosi", bus.SD_MOSI, 1'b1);
    check("reset busy", bus.busy, 1'b0);
    check("reset terr", bus.timeout_err, 1'b0);

    for (int i = 0; i < 14; i++) begin
      @(negedge SD_CK);
      bus.init_ok = vecs[i].init_ok;
      bus.req     = vecs[i].req;
      bus.mosi_i  = vecs[i].mosi;
      bus.csn_i   = vecs[i].csn;
      @(posedge SD_CK); #1;
      check($sformatf("vec%0d gnt", i),  bus.gnt, vecs[i].exp_gnt);
      check($sformatf("vec%0d csn", i),  bus.SD_CSn, vecs[i].exp_csn);
      check($sformatf("vec%0d mosi", i), bus.SD_MOSI, vecs[i].exp_mosi);
      check($sformatf("vec%0d busy", i), bus.busy, vecs[i].exp_busy);
      check($sformatf("vec%0d terr", i), bus.timeout_err, 1'b0);
    end

    // Round-robin: read owns now; each owner releases for one cycle, the other wins.
    owner       = 3'b010;
    exp_next[0] = 3'b100;
    exp_next[1] = 3'b010;
    for (int k = 0; k < 2; k++) begin
      @(negedge SD_CK);
      bus.csn_i = ~owner;
      @(posedge SD_CK); #1;
      check($sformatf("rr%0d owner csn", k), bus.SD_CSn, 1'b0);
      @(negedge SD_CK);
      bus.req   = 3'b110 & ~owner;
      bus.csn_i = 3'b111;
      @(posedge SD_CK); #1;
      zero_cyc = 0; busy_cyc = 0; csn_hi = 0; seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
        if (bus.gnt != 3'b000) seen = 1;
        else begin
          zero_cyc++;
          if (bus.busy)   busy_cyc++;
          if (bus.SD_CSn) csn_hi++;
          @(negedge SD_CK);
          bus.req = 3'b110;
          @(posedge SD_CK); #1;
        end
      end
      check($sformatf("rr%0d regrant seen", k), 16'(seen), 16'd1);
      check($sformatf("rr%0d gnt", k), bus.gnt, exp_next[k]);
      check($sformatf("rr%0d idle cycles", k), 16'(zero_cyc), 16'(GAP + 1));
      check($sformatf("rr%0d gap cycles", k), 16'(busy_cyc), 16'(GAP));
      check($sformatf("rr%0d csn high cycles", k), 16'(csn_hi), 16'(GAP + 1));
      owner = bus.gnt;
    end

    // Release one cycle before the hold limit: no timeout.
    hold_run(4094, gcyc, pulses, eg, eb);
    check("hold4094 grant cycles", 16'(gcyc), 16'd4094);
    check("hold4094 timeout pulses", 16'(pulses), 16'd0);

    // Release on the same edge as the limit: counts as a timeout.
    hold_run(4095, gcyc, pulses, eg, eb);
    check("hold4095 grant cycles", 16'(gcyc), 16'd4095);
    check("hold4095 timeout pulses", 16'(pulses), 16'd1);

    // Never released: forced revoke, then blocked until req toggles.
    hold_run(99999, gcyc, pulses, eg, eb);
    check("timeout grant cycles", 16'(gcyc), 16'd4095);
    check("timeout pulses", 16'(pulses), 16'd1);
    check("revoked not regranted gnt", eg, 3'b000);
    check("revoked not regranted busy", eb, 1'b0);
    @(negedge SD_CK);
    bus.req = 3'b000;
    @(negedge SD_CK);
    bus.req = 3'b010;
    seen = 0;
    for (int n = 0; n < 5 && !seen; n++) begin
      @(posedge SD_CK); #1;
      if (bus.gnt == 3'b010) seen = 1;
    end
    check("regrant after toggle", 16'(seen), 16'd1);

    // Card lost while write owns the bus.
    apply_reset();
    bus.init_ok = 1'b1;
    bus.req     = 3'b100;
    @(posedge SD_CK); #1;
    check("write gnt", bus.gnt, 3'b100);
    @(negedge SD_CK);
    bus.init_ok = 1'b0;
    @(posedge SD_CK); #1;
    check("card lost gnt", bus.gnt, 3'b000);
    check("card lost terr", bus.timeout_err, 1'b0);
    check("card lost busy", bus.busy, 1'b1);

    // Noise on the lanes while nobody holds a grant.
    bad = 0;
    terr_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge SD_CK);
      bus.req    = {2'($urandom_range(0, 3)), 1'b0};
      bus.mosi_i = 3'($urandom);
      bus.csn_i  = 3'($urandom);
      #1;
      if (bus.SD_MOSI !== 1'b1 || bus.SD_CSn !== 1'b1) bad++;
      @(posedge SD_CK); #1;
      if (bus.SD_MOSI !== 1'b1 || bus.SD_CSn !== 1'b1) bad++;
      if (bus.timeout_err) terr_cnt++;
    end
    check("idle lanes forced high", 16'(bad), 16'd0);
    check("idle no timeout", 16'(terr_cnt), 16'd0);
    check("idle gnt", bus.gnt, 3'b000);
    check("idle busy", bus.busy, 1'b0);

    // Asynchronous reset in the middle of a grant.
    apply_reset();
    bus.init_ok = 1'b1;
    bus.req     = 3'b010;
    @(posedge SD_CK); #1;
    check("pre-reset gnt", bus.gnt, 3'b010);
    @(negedge SD_CK);
    bus.csn_i  = 3'b101;
    bus.mosi_i = 3'b000;
    #1;
    check("pre-reset csn", bus.SD_CSn, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async reset gnt",  bus.gnt, 3'b000);
    check("async reset csn",  bus.SD_CSn, 1'b1);
    check("async reset mosi", bus.SD_MOSI, 1'b1);
    check("async reset busy", bus.busy, 1'b0);
    @(negedge SD_CK);
    rst     = 1'b0;
    bus.req = 3'b110;
    @(posedge SD_CK); #1;
    check("post-reset tie to read", bus.gnt, 3'b010);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sd_bus_arbiter.md
# sd_bus_arbiter

Shares the single SPI link to the SD card (SD_MOSI, SD_CSn) between three command engines: the initialisation engine, the block-read engine and the block-write engine. Before the card reports initialised, only the init engine may own the bus. Afterwards, read and write alternate round-robin. The arbiter enforces an idle gap with CS high between owners, and revokes a grant that is held too long. It sits between the engines and the SD pins; SD_MISO fans out to all engines directly and is not routed through this block.

## Interface
- HOLD_MAX, 4095: maximum cycles a grant may be held before forced revocation (12-bit counter).
- GAP_CYCLES, 8: idle cycles with SD_CSn=1 and SD_MOSI=1 between consecutive owners (1..15).

- SD_CK  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- init_ok  in  1  card initialised; level from the init engine.
- req  in  3  bus requests; bit0 init, bit1 read, bit2 write; a requester holds its bit high for the whole transaction.
- mosi_i  in  3  per-requester MOSI, same bit order.
- csn_i  in  3  per-requester chip select (active low).
- gnt  out  3  one-hot grant, registered.
- SD_MOSI  out  1  muxed MOSI to the card.
- SD_CSn  out  1  muxed chip select to the card.
- busy  out  1  high in GRANT or GAP.
- timeout_err  out  1  one-cycle pulse on forced revocation.

## Operation
- States: IDLE, GRANT, GAP. Registered owner index `own` (2 bits). Registered `last_rw` records the last served of read/write.
- Eligibility:
  - when init_ok=0, only req[0] is eligible;
  - when init_ok=1, req[0] is ignored and req[1]/req[2] are eligible.
- IDLE: if any eligible request, go to GRANT and set gnt one-hot and `own`.
  - If req[1] and req[2] are both eligible, grant the one that is not `last_rw`.
  - Update `last_rw` on every read/write grant.
- GRANT:
  - SD_MOSI=mosi_i[own] and SD_CSn=csn_i[own] (combinational mux from the registered `own`).
  - Hold counter increments each cycle.
- Leave GRANT for GAP, clearing gnt on the same edge, when any of these holds:
  - (a) req[own]=0 (normal release);
  - (b) hold counter reaches HOLD_MAX-1 (forced; timeout_err=1 for that one cycle);
  - (c) own is read or write and init_ok=0 (card lost; no timeout_err);
  - (d) own is init and init_ok=1 (no timeout_err).
- GAP:
  - SD_CSn=1, SD_MOSI=1, gnt=0.
  - Gap counter runs GAP_CYCLES cycles, then the block returns to IDLE.
  - Requests arriving during GAP are held pending and are not granted early.
- Outside GRANT: SD_CSn=1 and SD_MOSI=1 regardless of inputs.
- A requester whose grant was revoked must drop req for at least one cycle before it is re-eligible.
  - Per-requester `revoked` flag is set on a forced exit and cleared when req goes low.
- Simultaneous events:
  - A release and a timeout on the same cycle count as a timeout: timeout_err pulses.
  - An init_ok change on the same cycle as a grant decision uses the sampled init_ok value.

## Timing
- Reset values:
  - gnt=000, SD_CSn=1, SD_MOSI=1, busy=0, timeout_err=0;
  - state=IDLE, own=0, last_rw=write (read wins the first tie), counters=0, revoked=000.
- Grant latency: req sampled high at edge N in IDLE gives gnt high after edge N (visible cycle N+1).
  - The requester drives csn_i low only while its gnt=1.
- Release: req low sampled at edge M gives gnt=0 and SD_CSn=1 after edge M.
  - Next grant is no earlier than edge M+GAP_CYCLES+1.
- Hold counter resets to 0 on entry to GRANT.
  - A grant lasting exactly HOLD_MAX-1 cycles with normal release produces no timeout.
- Async reset mid-GRANT: gnt drops and SD_CSn goes to 1 immediately, without waiting for a clock edge.

## Test plan
- Reset then init_ok=0, req=011: gnt=001 one cycle after sampling; req[1] stays ungranted; SD_CSn follows csn_i[0]; on req[0] drop, 8 gap cycles with CSn=1, then gnt stays 000.
- init_ok=1, req=110 held: grants alternate 010, 100, 010, each separated by exactly 8 cycles of SD_CSn=1.
- init_ok=1, read holds req for 4100 cycles: gnt[1] drops after 4095 cycles, timeout_err pulses once, and read is not re-granted until req[1] toggles low.
- Write granted, init_ok falls: gnt=000 on the next edge, no timeout_err, then GAP.
- req toggled during GAP and while idle, and mosi_i/csn_i driven randomly outside GRANT: SD_MOSI=1 and SD_CSn=1 throughout.
- rst asserted mid-GRANT: all outputs at reset values asynchronously; after release, arbitration restarts with read winning the first tie.
